// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the index of the final add/shift iteration.
package mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] ITER_LAST = 2'd3;

endpackage

// File: rtl/shift_add_multiplier_4bit_if.sv
// Request/result bundle between the surrounding datapath (master) and the
// multiplier (slave).
interface shift_add_multiplier_4bit_if;

   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic [7:0] product;
   logic       busy;
   logic       done;

   modport master (
      output start, a, b,
      input  product, busy, done
   );

   modport slave (
      input  start, a, b,
      output product, busy, done
   );

endinterface

// File: rtl/full_adder_4bit.sv
// 4-bit ripple-style adder with carry in/out; purely combinational.
module full_adder_4bit (
   input  logic [3:0] inA,
   input  logic [3:0] inB,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] sum;

   assign sum  = {1'b0, inA} + {1'b0, inB} + {4'd0, cin};
   assign s    = sum[3:0];
   assign cout = sum[4];

endmodule

// File: rtl/shift_add_multiplier_4bit.sv
// Sequential 4x4 unsigned multiplier: four add/shift iterations through
// full_adder_4bit, then one DONE cycle that presents the registered product.
module shift_add_multiplier_4bit
   import mult_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   shift_add_multiplier_4bit_if.slave  bus
);

   state_t     state;
   logic [3:0] mcand;
   logic [3:0] acc;
   logic [3:0] mq;
   logic [1:0] cnt;
   logic [7:0] product;
   logic       busy;
   logic       done;

   logic [3:0] add_b;
   logic [3:0] add_s;
   logic       add_cout;
   logic [7:0] shifted;

   // Add the multiplicand only when the current multiplier bit is set.
   assign add_b = mq[0] ? mcand : 4'd0;

   full_adder_4bit u_adder (
      .inA  (acc),
      .inB  (add_b),
      .cin  (1'b0),
      .s    (add_s),
      .cout (add_cout)
   );

   // Carry lands in acc[3], so the full 8-bit product is never truncated.
   assign shifted = {add_cout, add_s, mq[3:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         mcand   <= 4'd0;
         acc     <= 4'd0;
         mq      <= 4'd0;
         cnt     <= 2'd0;
         product <= 8'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (bus.start) begin
                  mcand <= bus.a;
                  mq    <= bus.b;
                  acc   <= 4'd0;
                  cnt   <= 2'd0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               {acc, mq} <= shifted;
               cnt       <= cnt + 2'd1;
               if (cnt == ITER_LAST) begin
                  product <= shifted;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.product = product;
   assign bus.busy    = busy;
   assign bus.done    = done;

endmodule

// File: tb/tb_shift_add_multiplier_4bit.sv
// Self-checking bench for shift_add_multiplier_4bit; expected products come
// from plain integer multiplication and expected timing from a cycle table.
module tb_shift_add_multiplier_4bit;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   shift_add_multiplier_4bit_if bus ();

   shift_add_multiplier_4bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one op, then wait (bounded) for done; lat = edges after accept.
   task automatic do_op(input logic [3:0] op_a, input logic [3:0] op_b,
                        output logic [7:0] p, output int lat, output logic busy_seen);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = op_a;
      bus.b     = op_b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 4'($urandom);
      bus.b     = 4'($urandom);
      busy_seen = bus.busy;
      lat       = 0;
      while (bus.done !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      p = bus.product;
   endtask

   task automatic test_reset();
      bus.start = 1'b1;
      bus.a     = 4'd9;
      bus.b     = 4'd9;
      rst_n     = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (bus.product !== 8'h00) begin
         errors++;
         $display("FAIL reset_product: got %h want 00", bus.product);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b want 0", bus.busy);
      end
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_done: got %b want 0", bus.done);
      end
      bus.start = 1'b0;
      rst_n     = 1'b1;
      $display("reset: product=%h busy=%b done=%b", bus.product, bus.busy, bus.done);
   endtask

   task automatic test_directed();
      logic [3:0] ta [4] = '{4'd0, 4'd15, 4'd13, 4'd1};
      logic [3:0] tb [4] = '{4'd0, 4'd15, 4'd11, 4'd8};
      logic [7:0] want [4] = '{8'h00, 8'hE1, 8'h8F, 8'h08};
      logic [7:0] p;
      int lat;
      logic bs;
      for (int i = 0; i < 4; i++) begin
         do_op(ta[i], tb[i], p, lat, bs);
         $display("directed: a=%0d b=%0d product=%h lat=%0d", ta[i], tb[i], p, lat);
         checks++;
         if (p !== want[i]) begin
            errors++;
            $display("FAIL directed_product: a=%0d b=%0d got %h want %h", ta[i], tb[i], p, want[i]);
         end
         checks++;
         if (lat !== 4) begin
            errors++;
            $display("FAIL directed_latency: got %0d want 4", lat);
         end
         checks++;
         if (bs !== 1'b1) begin
            errors++;
            $display("FAIL directed_busy: got %b want 1", bs);
         end
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0 || bus.product !== want[i]) begin
            errors++;
            $display("FAIL directed_hold: done=%b product=%h want done=0 product=%h",
                     bus.done, bus.product, want[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic       exp_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic       exp_done [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0] oa;
      logic [3:0] ob;
      logic [7:0] want;
      @(negedge clk);
      oa        = 4'($urandom);
      ob        = 4'($urandom);
      bus.start = 1'b1;
      bus.a     = oa;
      bus.b     = ob;
      for (int op = 0; op < 5; op++) begin
         want = 8'(oa * ob);
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== exp_busy[k] || bus.done !== exp_done[k]) begin
               errors++;
               $display("FAIL b2b_pattern: op=%0d cycle=%0d busy=%b done=%b want busy=%b done=%b",
                        op, k, bus.busy, bus.done, exp_busy[k], exp_done[k]);
            end
            if (k == 4) begin
               checks++;
               if (bus.product !== want) begin
                  errors++;
                  $display("FAIL b2b_product: op=%0d got %h want %h", op, bus.product, want);
               end
               $display("b2b: op=%0d a=%0d b=%0d product=%h", op, oa, ob, bus.product);
            end
            if (k == 5) begin
               oa    = 4'($urandom);
               ob    = 4'($urandom);
               bus.a = oa;
               bus.b = ob;
            end
         end
      end
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
   endtask

   task automatic test_ignore_start();
      logic [7:0] p;
      int lat;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'd6;
      bus.b     = 4'd9;
      @(negedge clk);
      lat = 0;
      for (int k = 0; k < 3; k++) begin
         bus.start = 1'($urandom);
         bus.a     = 4'($urandom);
         bus.b     = 4'($urandom);
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      while (bus.done !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      p = bus.product;
      $display("ignore_start: product=%h lat=%0d", p, lat);
      checks++;
      if (p !== 8'd54 || lat !== 4) begin
         errors++;
         $display("FAIL ignore_start: got product=%h lat=%0d want 36 lat=4", p, lat);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start_idle: busy=%b want 0", bus.busy);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] p;
      int lat;
      logic bs;
      int seen_done;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'd5;
      bus.b     = 4'd5;
      repeat (3) @(negedge clk);
      bus.start = 1'b0;
      rst_n     = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 8'h00) begin
         errors++;
         $display("FAIL midrun_reset: busy=%b done=%b product=%h want 0 0 00",
                  bus.busy, bus.done, bus.product);
      end
      seen_done = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen_done++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
      end
      checks++;
      if (seen_done !== 0) begin
         errors++;
         $display("FAIL midrun_no_done: activity cycles=%0d want 0", seen_done);
      end
      do_op(4'd7, 4'd9, p, lat, bs);
      $display("midrun: next op 7*9 product=%h lat=%0d", p, lat);
      checks++;
      if (p !== 8'h3F || lat !== 4) begin
         errors++;
         $display("FAIL midrun_next_op: got product=%h lat=%0d want 3f lat=4", p, lat);
      end
   endtask

   task automatic test_random();
      logic [3:0] ra;
      logic [3:0] rb;
      logic [7:0] p;
      int lat;
      logic bs;
      for (int i = 0; i < 12; i++) begin
         ra = 4'($urandom);
         rb = 4'($urandom);
         do_op(ra, rb, p, lat, bs);
         $display("random: a=%0d b=%0d product=%h", ra, rb, p);
         checks++;
         if (p !== 8'(ra * rb) || lat !== 4) begin
            errors++;
            $display("FAIL random_product: a=%0d b=%0d got %h lat=%0d want %h lat=4",
                     ra, rb, p, lat, 8'(ra * rb));
         end
      end
   endtask

   task automatic test_exhaustive();
      logic [7:0] p;
      int lat;
      logic bs;
      int bad;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            do_op(4'(i), 4'(j), p, lat, bs);
            checks++;
            if (p !== 8'(i * j) || lat !== 4) begin
               errors++;
               bad++;
               $display("FAIL exhaustive: a=%0d b=%0d got %h lat=%0d want %h lat=4",
                        i, j, p, lat, 8'(i * j));
            end
         end
      end
      $display("exhaustive: 256 pairs, %0d wrong", bad);
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = 4'd0;
      bus.b     = 4'd0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid_run();
      test_random();
      test_exhaustive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
